// File: rtl/keycode_event_queue.sv
// Debounces the SoC's level-style keycode and turns accepted changes into a queue of
// press / release / auto-repeat events, drained by the consumer through a valid/ready handshake.
module keycode_event_queue #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [7:0]                    keycode,
  input  logic                          clear_overflow,
  input  logic                          ev_ready,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic [1:0]                    ev_type,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SW   = $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX + 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DELAY  = 2'b01,
    S_REPEAT = 2'b10
  } rep_state_e;

  logic [7:0]    kc_q, kc_d;
  logic [7:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    acc_q, acc_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_code_q, pend_code_d;
  rep_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_code_q, last_code_d;
  logic [1:0]    last_type_q, last_type_d;
  logic [7:0]    mem_code_q [FIFO_DEPTH];
  logic [7:0]    mem_code_d [FIFO_DEPTH];
  logic [1:0]    mem_type_q [FIFO_DEPTH];
  logic [1:0]    mem_type_d [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic [7:0]    push_code;
  logic [1:0]    push_type;
  logic          empty, full, pop, wr_en, drop;

  // Stability filter: the candidate must match kc_q for STABLE_CYCLES cycles to be accepted.
  always_comb begin
    kc_d   = keycode;
    cand_d = cand_q;
    stab_d = stab_q;
    acc_d  = acc_q;
    accept = 1'b0;
    if (kc_q != cand_q) begin
      cand_d = kc_q;
      stab_d = SW'(1);
    end else if (stab_q == SW'(STABLE_CYCLES - 1)) begin
      if (cand_q != acc_q) begin
        accept = 1'b1;
        acc_d  = cand_q;
      end else begin
        acc_d = acc_q;
      end
    end else begin
      stab_d = stab_q + SW'(1);
    end
  end

  // Event generation and repeat FSM; an acceptance outranks both a pending press and a due repeat.
  always_comb begin
    push        = 1'b0;
    push_code   = 8'h00;
    push_type   = EV_PRESS;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (accept) begin
      push = 1'b1;
      if (acc_q != 8'h00) begin
        push_code = acc_q;
        push_type = EV_RELEASE;
        if (cand_q != 8'h00) begin
          pend_d      = 1'b1;
          pend_code_d = cand_q;
        end else begin
          pend_d = 1'b0;
        end
      end else begin
        push_code = cand_q;
        push_type = EV_PRESS;
      end
      state_d = (cand_q != 8'h00) ? S_DELAY : S_IDLE;
      cnt_d   = '0;
    end else if (pend_q) begin
      push      = 1'b1;
      push_code = pend_code_q;
      push_type = EV_PRESS;
      state_d   = S_DELAY;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (cnt_q == CW'(REPEAT_DELAY - 1)) begin
            push      = 1'b1;
            push_code = acc_q;
            push_type = EV_REPEAT;
            state_d   = S_REPEAT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REPEAT: begin
          if (cnt_q == CW'(REPEAT_PERIOD - 1)) begin
            push      = 1'b1;
            push_code = acc_q;
            push_type = EV_REPEAT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Event FIFO: a push into a full queue survives only if the head is popped in the same cycle.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == (AW + 1)'(FIFO_DEPTH));
    pop         = !empty && ev_ready;
    wr_en       = push && (!full || pop);
    drop        = push && full && !pop;
    mem_code_d  = mem_code_q;
    mem_type_d  = mem_type_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_code_d = last_code_q;
    last_type_d = last_type_q;
    if (wr_en) begin
      mem_code_d[wr_ptr_q] = push_code;
      mem_type_d[wr_ptr_q] = push_type;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      last_code_d = mem_code_q[rd_ptr_q];
      last_type_d = mem_type_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      kc_q        <= 8'h00;
      cand_q      <= 8'h00;
      stab_q      <= '0;
      acc_q       <= 8'h00;
      pend_q      <= 1'b0;
      pend_code_q <= 8'h00;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_code_q <= 8'h00;
      last_type_q <= 2'b00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_code_q[i] <= 8'h00;
        mem_type_q[i] <= 2'b00;
      end
    end else begin
      kc_q        <= kc_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_code_q <= last_code_d;
      last_type_q <= last_type_d;
      mem_code_q  <= mem_code_d;
      mem_type_q  <= mem_type_d;
    end
  end

  // Show-ahead head; an empty queue keeps presenting the last event handed out.
  always_comb begin
    ev_valid   = !empty;
    fifo_count = count_q;
    overflow   = overflow_q;
    if (empty) begin
      ev_code = last_code_q;
      ev_type = last_type_q;
    end else begin
      ev_code = mem_code_q[rd_ptr_q];
      ev_type = mem_type_q[rd_ptr_q];
    end
  end

endmodule
